// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter
// Shares one SPI master between N requesters. A round-robin scan picks a
// winner. The block then issues the master's start strobe and follows the
// master's LOAD line through the frame. When the frame ends it returns the
// received word with a per-requester done pulse. A timeout ends the frame
// if the master never completes it. A fixed idle gap separates frames.

module spi_frame_arbiter #(
    parameter int N           = 4,
    parameter int M           = 9,
    parameter int GAP_CYC     = 50,
    parameter int TIMEOUT_CYC = 2048,
    parameter int PTR_W       = 3
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [N-1:0]   req,
    input  logic [N*M-1:0] req_data,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [M-1:0]   rx_data,
    output logic           err,
    output logic           busy,
    output logic           spi_st,
    output logic [M-1:0]   spi_di,
    input  logic           spi_load,
    input  logic [M-1:0]   spi_do
);

    // Counters get one bit of headroom beyond their terminal count, so
    // neither of them can wrap.
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int GAP_W = $clog2(GAP_CYC) + 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_CAPTURE   = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [PTR_W-1:0] ptr_reg;      // last winner
    logic [PTR_W-1:0] win_reg;      // winner of the frame in flight
    logic [PTR_W-1:0] win_next;     // combinational round-robin pick
    logic [M-1:0]     di_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [N-1:0]     done_reg;
    logic [M-1:0]     rx_reg;
    logic             err_reg;

    logic [M-1:0]     word [N];
    logic [N-1:0]     above_ptr;
    logic [N-1:0]     req_hi;
    logic [N-1:0]     win_onehot;
    logic [N-1:0]     sel_onehot;
    logic [M-1:0]     sel_data;

    logic             launch;
    logic             in_wait;
    logic             timeout_hit;

    // Per-requester slicing and one-hot decodes.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign word[gi]       = req_data[gi*M +: M];
            assign above_ptr[gi]  = (PTR_W'(gi) > ptr_reg);
            assign win_onehot[gi] = (win_reg == PTR_W'(gi));
            assign sel_onehot[gi] = (win_next == PTR_W'(gi));
            assign grant[gi]      = spi_st && win_onehot[gi];
        end
    endgenerate

    // Requests strictly above the pointer take priority. If there are none,
    // the scan wraps to the lowest set request.
    assign req_hi = req & above_ptr;

    // Round-robin pick: the lowest set bit of req_hi, otherwise the lowest
    // set bit of req.
    always_comb begin
        win_next = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_next = PTR_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                win_next = PTR_W'(i);
            end
        end
    end

    // Transmit word of the requester that is about to be granted.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) begin
                sel_data = word[i];
            end
        end
    end

    assign launch  = (state_reg == S_IDLE) && (|req);
    assign in_wait = (state_reg == S_WAIT_LOW) || (state_reg == S_WAIT_HIGH);

    // A LOAD rise seen in WAIT_HIGH is a real completion. It takes
    // precedence over a timeout that expires on the same cycle.
    assign timeout_hit = (tmo_reg == TMO_LAST) &&
                         ((state_reg == S_WAIT_LOW) ||
                          ((state_reg == S_WAIT_HIGH) && !spi_load));

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (|req) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (timeout_hit) begin
                    state_next = S_GAP;
                end else if (!spi_load) begin
                    state_next = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (spi_load) begin
                    state_next = S_CAPTURE;
                end else if (timeout_hit) begin
                    state_next = S_GAP;
                end
            end
            S_CAPTURE: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Latch the winner, the pointer and the transmit word on entry to START.
    // spi_di then holds until the next grant.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_reg <= PTR_RST;
            win_reg <= '0;
            di_reg  <= '0;
        end else if (launch) begin
            ptr_reg <= win_next;
            win_reg <= win_next;
            di_reg  <= sel_data;
        end
    end

    // Frame timeout counter. It is zero during IDLE and counts from the
    // START cycle, so a stuck frame reports done TIMEOUT_CYC cycles after
    // the strobe. It saturates rather than wrapping.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tmo_reg <= '0;
        end else if ((state_reg == S_START) || in_wait) begin
            if (tmo_reg != TMO_MAX) begin
                tmo_reg <= tmo_reg + TMO_W'(1);
            end
        end else begin
            tmo_reg <= '0;
        end
    end

    // Inter-frame gap counter. It runs only in GAP.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gap_reg <= '0;
        end else if (state_reg == S_GAP) begin
            if (gap_reg != GAP_LAST) begin
                gap_reg <= gap_reg + GAP_W'(1);
            end
        end else begin
            gap_reg <= '0;
        end
    end

    // Completion outputs. done and err are one-cycle pulses. rx_data is
    // registered on the same edge, so all three are valid together. The
    // capture edge is the second edge after LOAD is seen high, by which time
    // the master has latched its receive word.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            done_reg <= '0;
            rx_reg   <= '0;
            err_reg  <= 1'b0;
        end else begin
            done_reg <= '0;
            err_reg  <= 1'b0;
            if (state_reg == S_CAPTURE) begin
                done_reg <= win_onehot;
                rx_reg   <= spi_do;
            end else if (timeout_hit) begin
                done_reg <= win_onehot;
                rx_reg   <= '0;
                err_reg  <= 1'b1;
            end
        end
    end

    assign spi_st  = (state_reg == S_START);
    assign busy    = (state_reg != S_IDLE);
    assign spi_di  = di_reg;
    assign done    = done_reg;
    assign rx_data = rx_reg;
    assign err     = err_reg;

endmodule
